// File: rtl/mdu_pkg.sv
// ============================================================================
// Module : mdu_pkg
// Brief  : Shared state encoding and iteration constants for mult_div_unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int ITER      = DEF_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } mdu_state_e;

endpackage : mdu_pkg

`default_nettype wire

// File: rtl/restoring_div_core.sv
// ============================================================================
// Module : restoring_div_core
// Brief  : One combinational restoring-divide step on unsigned magnitudes.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // The dividend MSB shifts out of the quotient register into the remainder.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});
    assign w_diff  = w_shift - {1'b0, i_divisor};

    assign o_rem = w_ge ? w_diff : w_shift;
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule : restoring_div_core

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module : mult_div_unit
// Brief  : Sequential signed multiply (radix-2 Booth) / divide (restoring)
//          unit producing HI/LO. Optional macro MDU_DIV_ZERO_EXC_EN adds
//          the div_zero output and a fast divide-by-zero exit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
`ifdef MDU_DIV_ZERO_EXC_EN
    output logic             div_zero,
`endif
    output logic             done
);

    localparam logic [CNT_W-1:0] c_iter = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(1);

    mdu_state_e        state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [WIDTH:0]    acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]  acc_lo_q,  acc_lo_d;
    logic              qm1_q,     qm1_d;
    logic [WIDTH-1:0]  mcand_q,   mcand_d;
    logic              is_div_q,  is_div_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]  hi_q,      hi_d;
    logic [WIDTH-1:0]  lo_q,      lo_d;
    logic              done_q,    done_d;
`ifdef MDU_DIV_ZERO_EXC_EN
    logic              dz_q,      dz_d;
    logic              div_zero_q, div_zero_d;
`endif

    logic [WIDTH-1:0]  w_a_abs;
    logic [WIDTH-1:0]  w_b_abs;
    logic [WIDTH:0]    w_mcand_ext;
    logic [WIDTH:0]    w_booth_sum;
    logic [WIDTH:0]    w_div_rem;
    logic [WIDTH-1:0]  w_div_quo;
    logic [WIDTH-1:0]  w_res_hi;
    logic [WIDTH-1:0]  w_res_lo;

    assign w_a_abs     = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
    assign w_b_abs     = b_in[WIDTH-1] ? ('0 - b_in) : b_in;
    // One guard bit on P_hi keeps the shift correct when adding/subtracting the most negative value.
    assign w_mcand_ext = {mcand_q[WIDTH-1], mcand_q};

    always_comb begin
        w_booth_sum = acc_hi_q;
        case ({acc_lo_q[0], qm1_q})
            2'b01:   w_booth_sum = acc_hi_q + w_mcand_ext;
            2'b10:   w_booth_sum = acc_hi_q - w_mcand_ext;
            default: w_booth_sum = acc_hi_q;
        endcase
    end

    restoring_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .i_rem     (acc_hi_q[WIDTH-1:0]),
        .i_quo     (acc_lo_q),
        .i_divisor (mcand_q),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    always_comb begin
        w_res_hi = acc_hi_q[WIDTH-1:0];
        w_res_lo = acc_lo_q;
        if (is_div_q) begin
            w_res_hi = neg_rem_q ? ('0 - acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
            w_res_lo = neg_quo_q ? ('0 - acc_lo_q) : acc_lo_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef MDU_DIV_ZERO_EXC_EN
        dz_d       = dz_q;
        div_zero_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    acc_hi_d  = '0;
                    acc_lo_d  = b_in;
                    qm1_d     = 1'b0;
                    mcand_d   = a_in;
                    is_div_d  = 1'b0;
                    cnt_d     = c_iter;
                    state_d   = MULT;
`ifdef MDU_DIV_ZERO_EXC_EN
                    dz_d      = 1'b0;
`endif
                end else if (start_div) begin
                    acc_hi_d  = '0;
                    acc_lo_d  = w_a_abs;
                    qm1_d     = 1'b0;
                    mcand_d   = w_b_abs;
                    is_div_d  = 1'b1;
                    // A zero divisor leaves the all-ones quotient unnegated.
                    neg_quo_d = (a_in[WIDTH-1] ^ b_in[WIDTH-1]) && (b_in != '0);
                    neg_rem_d = a_in[WIDTH-1];
                    cnt_d     = c_iter;
                    state_d   = DIV;
`ifdef MDU_DIV_ZERO_EXC_EN
                    dz_d      = (b_in == '0);
                    if (b_in == '0) begin
                        state_d = FINISH;
                    end
`endif
                end
            end
            MULT: begin
                acc_hi_d = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
                acc_lo_d = {w_booth_sum[0], acc_lo_q[WIDTH-1:1]};
                qm1_d    = acc_lo_q[0];
                cnt_d    = cnt_q - c_last;
                if (cnt_q == c_last) begin
                    state_d = FINISH;
                end
            end
            DIV: begin
                acc_hi_d = w_div_rem;
                acc_lo_d = w_div_quo;
                cnt_d    = cnt_q - c_last;
                if (cnt_q == c_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MDU_DIV_ZERO_EXC_EN
                div_zero_d = dz_q;
                if (!dz_q) begin
                    hi_d = w_res_hi;
                    lo_d = w_res_lo;
                end
`else
                hi_d = w_res_hi;
                lo_d = w_res_lo;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            qm1_q     <= 1'b0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
`ifdef MDU_DIV_ZERO_EXC_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            qm1_q     <= qm1_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
`ifdef MDU_DIV_ZERO_EXC_EN
            dz_q       <= dz_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);
`ifdef MDU_DIV_ZERO_EXC_EN
    assign div_zero = div_zero_q;
`endif

endmodule : mult_div_unit

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module : tb_mult_div_unit
// Brief  : Directed self-checking bench for mult_div_unit (both macro builds).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
`ifdef MDU_DIV_ZERO_EXC_EN
    logic        div_zero;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          lat;
    logic        busy_all;
    logic        dz_seen;

    always #5 clk = ~clk;

    mult_div_unit #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a_in       (a_in),
        .b_in       (b_in),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
`ifdef MDU_DIV_ZERO_EXC_EN
        .div_zero   (div_zero),
`endif
        .done       (done)
    );

    // Starts an operation and waits (bounded) for done; latency counts edges after E0.
    task automatic run_op(input logic sm, input logic sd, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at,
                          output int latency, output logic busy_ok);
        start_mult = sm;
        start_div  = sd;
        a_in       = a;
        b_in       = b;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = 32'h1234_5678;
        b_in       = 32'h0000_0003;
        latency    = 0;
        busy_ok    = 1'b1;
        dz_seen    = 1'b0;
        while (latency < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inject_at > 0 && latency == inject_at - 1) begin
                start_mult = 1'b1;
                a_in       = 32'd3;
                b_in       = 32'd3;
            end
            @(posedge clk);
            #1;
            start_mult = 1'b0;
            latency++;
            if (done === 1'b1) begin
`ifdef MDU_DIV_ZERO_EXC_EN
                dz_seen = div_zero;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL reset_hi: got %h expected 00000000", hi_out); end
        n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL reset_lo: got %h expected 00000000", lo_out); end
        reset = 1'b0;
    endtask

    task automatic test_mult_basic();
        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, busy_all);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL mult_latency: got %0d expected 33", lat); end
        n_cmp++; if (busy_all !== 1'b1) begin n_bad++; $display("FAIL mult_busy: got %b expected 1", busy_all); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
        n_cmp++; if (hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi_out); end
        n_cmp++; if (lo_out !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo: got %h expected ffffffeb", lo_out); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b expected 0", done); end
        n_cmp++; if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
            n_bad++; $display("FAIL hold: got %h_%h expected ffffffff_ffffffeb", hi_out, lo_out);
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, busy_all);
        n_cmp++; if (hi_out !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi: got %h expected 40000000", hi_out); end
        n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL mult_min_lo: got %h expected 00000000", lo_out); end
        // Started in the done cycle; both starts high selects multiply.
        run_op(1'b1, 1'b1, 32'd3, 32'd5, 0, lat, busy_all);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL b2b_latency: got %0d expected 33", lat); end
        n_cmp++; if (lo_out !== 32'd15) begin n_bad++; $display("FAIL both_start_lo: got %h expected 0000000f", lo_out); end
        n_cmp++; if (hi_out !== 32'd0) begin n_bad++; $display("FAIL both_start_hi: got %h expected 00000000", hi_out); end
    endtask

    task automatic test_div_signed();
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, busy_all);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL div_latency: got %0d expected 33", lat); end
        n_cmp++; if (lo_out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_neg_quo: got %h expected fffffffd", lo_out); end
        n_cmp++; if (hi_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_neg_rem: got %h expected ffffffff", hi_out); end
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, busy_all);
        n_cmp++; if (lo_out !== 32'h8000_0000) begin n_bad++; $display("FAIL div_ovf_quo: got %h expected 80000000", lo_out); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL div_ovf_rem: got %h expected 00000000", hi_out); end
    endtask

    task automatic test_div_zero();
        logic [31:0] hi_prev;
        logic [31:0] lo_prev;
        hi_prev = hi_out;
        lo_prev = lo_out;
        run_op(1'b0, 1'b1, 32'd5, 32'd0, 0, lat, busy_all);
`ifdef MDU_DIV_ZERO_EXC_EN
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL dz_latency: got %0d expected 1", lat); end
        n_cmp++; if (dz_seen !== 1'b1) begin n_bad++; $display("FAIL dz_flag: got %b expected 1", dz_seen); end
        n_cmp++; if (hi_out !== hi_prev) begin n_bad++; $display("FAIL dz_hi_held: got %h expected %h", hi_out, hi_prev); end
        n_cmp++; if (lo_out !== lo_prev) begin n_bad++; $display("FAIL dz_lo_held: got %h expected %h", lo_out, lo_prev); end
        run_op(1'b0, 1'b1, 32'd9, 32'd4, 0, lat, busy_all);
        n_cmp++; if (dz_seen !== 1'b0) begin n_bad++; $display("FAIL dz_spurious: got %b expected 0", dz_seen); end
`else
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL dz_latency: got %0d expected 33 (prev %h_%h)", lat, hi_prev, lo_prev); end
        n_cmp++; if (hi_out !== 32'd5) begin n_bad++; $display("FAIL dz_hi: got %h expected 00000005", hi_out); end
        n_cmp++; if (lo_out !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_lo: got %h expected ffffffff", lo_out); end
`endif
    endtask

    task automatic test_ignore_start();
        run_op(1'b0, 1'b1, 32'd100, 32'd7, 5, lat, busy_all);
        n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
        n_cmp++; if (lo_out !== 32'd14) begin n_bad++; $display("FAIL ignore_quo: got %h expected 0000000e", lo_out); end
        n_cmp++; if (hi_out !== 32'd2) begin n_bad++; $display("FAIL ignore_rem: got %h expected 00000002", hi_out); end
    endtask

    task automatic test_reset_midop();
        int dones;
        start_div = 1'b1;
        a_in      = 32'd100;
        b_in      = 32'd7;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        n_cmp++; if (hi_out !== 32'h0) begin n_bad++; $display("FAIL midreset_hi: got %h expected 00000000", hi_out); end
        n_cmp++; if (lo_out !== 32'h0) begin n_bad++; $display("FAIL midreset_lo: got %h expected 00000000", lo_out); end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL midreset_done: got %0d pulses expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_back_to_back();
        test_div_signed();
        test_div_zero();
        test_ignore_start();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mult_div_unit

`default_nettype wire
